// File: rtl/tcp_pkg.sv
// rtl/tcp_pkg.sv - shared widths, FSM states and helpers for the TCP TX flow scheduler
package tcp_pkg;

    localparam int FLOWID_W  = 3;
    localparam int MAX_FLOWS = 1 << FLOWID_W;
    localparam int CNT_W     = 32;

    typedef enum logic [1:0] {
        IDLE,
        OFFER,
        WAIT_UPDATE
    } sched_state_e;

    function automatic logic [MAX_FLOWS-1:0] flow_bit(input logic en, input logic [FLOWID_W-1:0] id);
        flow_bit = en ? (MAX_FLOWS'(1) << id) : '0;
    endfunction

endpackage

// File: rtl/tcp_tx_sched_rr_pick.sv
// rtl/tcp_tx_sched_rr_pick.sv - rotate-priority encoder: first pending flow at or after rr_ptr
module tcp_tx_sched_rr_pick
    import tcp_pkg::*;
(
    input  logic [MAX_FLOWS-1:0] pending,
    input  logic [FLOWID_W-1:0]  rr_ptr,
    output logic                 pick_val,
    output logic [FLOWID_W-1:0]  pick_flowid
);

    logic [FLOWID_W-1:0] cand [MAX_FLOWS];

    // Flow count is a power of two, so plain truncating addition wraps the scan
    for (genvar g = 0; g < MAX_FLOWS; g++) begin : g_cand
        assign cand[g] = rr_ptr + FLOWID_W'(g);
    end

    // Scan farthest-first so the nearest set bit is the last assignment
    always_comb begin
        pick_val    = 1'b0;
        pick_flowid = '0;
        for (int i = MAX_FLOWS - 1; i >= 0; i--) begin
            if (pending[cand[i]]) begin
                pick_val    = 1'b1;
                pick_flowid = cand[i];
            end
        end
    end

endmodule

// File: rtl/tcp_tx_flow_sched.sv
// rtl/tcp_tx_flow_sched.sv - round-robin flow scheduler feeding the single-issue TCP TX FSM
module tcp_tx_flow_sched
    import tcp_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                app_sched_wake_val,
    input  logic [FLOWID_W-1:0] app_sched_wake_flowid,
    output logic                sched_app_wake_rdy,
    input  logic                rx_sched_wake_val,
    input  logic [FLOWID_W-1:0] rx_sched_wake_flowid,
    output logic                sched_rx_wake_rdy,
    input  logic                flow_disable_val,
    input  logic [FLOWID_W-1:0] flow_disable_flowid,
    output logic                sched_tx_req_val,
    output logic [FLOWID_W-1:0] sched_tx_req_flowid,
    input  logic                tx_sched_req_rdy,
    input  logic                tx_sched_update_val,
    input  logic [FLOWID_W-1:0] tx_sched_update_flowid,
    input  logic                tx_sched_update_more,
    output logic                sched_tx_update_rdy,
    output logic                sched_idle,
    output logic [CNT_W-1:0]    sched_issue_cnt
);

    sched_state_e         state_q, state_d;
    logic [MAX_FLOWS-1:0] pending_q, pending_d;
    logic [FLOWID_W-1:0]  rr_ptr_q;
    logic [FLOWID_W-1:0]  offer_flowid_q;
    logic                 drop_flag_q, drop_flag_d;
    logic                 idle_q;
    logic [CNT_W-1:0]     cnt_q;

    logic [MAX_FLOWS-1:0] dis_mask, wake_set, acc_clr, rearm_set;
    logic                 pick_val;
    logic [FLOWID_W-1:0]  pick_flowid;
    logic                 accept, dis_offer, upd;

    assign dis_mask  = flow_bit(flow_disable_val, flow_disable_flowid);
    assign wake_set  = flow_bit(app_sched_wake_val, app_sched_wake_flowid)
                     | flow_bit(rx_sched_wake_val, rx_sched_wake_flowid);
    assign accept    = (state_q == OFFER) && tx_sched_req_rdy;
    assign dis_offer = flow_disable_val && (flow_disable_flowid == offer_flowid_q);
    assign upd       = (state_q == WAIT_UPDATE) && tx_sched_update_val;
    assign acc_clr   = flow_bit(accept, offer_flowid_q);
    assign rearm_set = flow_bit(upd && tx_sched_update_more && !drop_flag_q, tx_sched_update_flowid);

    // A flow being disabled this cycle must not be picked from the stale pending vector
    tcp_tx_sched_rr_pick u_rr_pick (
        .pending     (pending_q & ~dis_mask),
        .rr_ptr      (rr_ptr_q),
        .pick_val    (pick_val),
        .pick_flowid (pick_flowid)
    );

    // Sets win over the accept clear; disable wins over everything
    assign pending_d = ((pending_q & ~acc_clr) | wake_set | rearm_set) & ~dis_mask;

    always_comb begin
        state_d     = state_q;
        drop_flag_d = drop_flag_q;
        case (state_q)
            IDLE: begin
                if (pick_val) state_d = OFFER;
            end
            OFFER: begin
                if (accept) begin
                    state_d = WAIT_UPDATE;
                    if (dis_offer) drop_flag_d = 1'b1;
                end else if (dis_offer) begin
                    state_d = IDLE;
                end
            end
            WAIT_UPDATE: begin
                if (upd) begin
                    state_d     = IDLE;
                    drop_flag_d = 1'b0;
                end else if (dis_offer) begin
                    drop_flag_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            pending_q      <= '0;
            rr_ptr_q       <= '0;
            offer_flowid_q <= '0;
            drop_flag_q    <= 1'b0;
            idle_q         <= 1'b1;
            cnt_q          <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            drop_flag_q <= drop_flag_d;
            idle_q      <= (pending_d == '0) && (state_d == IDLE);
            if (state_q == IDLE && pick_val) offer_flowid_q <= pick_flowid;
            if (accept) begin
                rr_ptr_q <= offer_flowid_q + FLOWID_W'(1);
                cnt_q    <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign sched_app_wake_rdy  = 1'b1;
    assign sched_rx_wake_rdy   = 1'b1;
    assign sched_tx_req_val    = (state_q == OFFER);
    assign sched_tx_req_flowid = offer_flowid_q;
    assign sched_tx_update_rdy = (state_q == WAIT_UPDATE);
    assign sched_idle          = idle_q;
    assign sched_issue_cnt     = cnt_q;

`ifndef SYNTHESIS
    // Completion must name the flow currently in flight
    a_update_flow: assert property (@(posedge clk) disable iff (!rst)
        upd |-> (tx_sched_update_flowid == offer_flowid_q));
`endif

endmodule

// File: tb/tb_tcp_tx_flow_sched.sv
// tb/tb_tcp_tx_flow_sched.sv - self-checking bench for tcp_tx_flow_sched
module tb_tcp_tx_flow_sched;
    import tcp_pkg::*;

    logic                clk = 1'b0;
    logic                rst;
    logic                app_sched_wake_val;
    logic [FLOWID_W-1:0] app_sched_wake_flowid;
    logic                sched_app_wake_rdy;
    logic                rx_sched_wake_val;
    logic [FLOWID_W-1:0] rx_sched_wake_flowid;
    logic                sched_rx_wake_rdy;
    logic                flow_disable_val;
    logic [FLOWID_W-1:0] flow_disable_flowid;
    logic                sched_tx_req_val;
    logic [FLOWID_W-1:0] sched_tx_req_flowid;
    logic                tx_sched_req_rdy;
    logic                tx_sched_update_val;
    logic [FLOWID_W-1:0] tx_sched_update_flowid;
    logic                tx_sched_update_more;
    logic                sched_tx_update_rdy;
    logic                sched_idle;
    logic [CNT_W-1:0]    sched_issue_cnt;

    always #5 clk = ~clk;

    tcp_tx_flow_sched dut (
        .clk                    (clk),
        .rst                    (rst),
        .app_sched_wake_val     (app_sched_wake_val),
        .app_sched_wake_flowid  (app_sched_wake_flowid),
        .sched_app_wake_rdy     (sched_app_wake_rdy),
        .rx_sched_wake_val      (rx_sched_wake_val),
        .rx_sched_wake_flowid   (rx_sched_wake_flowid),
        .sched_rx_wake_rdy      (sched_rx_wake_rdy),
        .flow_disable_val       (flow_disable_val),
        .flow_disable_flowid    (flow_disable_flowid),
        .sched_tx_req_val       (sched_tx_req_val),
        .sched_tx_req_flowid    (sched_tx_req_flowid),
        .tx_sched_req_rdy       (tx_sched_req_rdy),
        .tx_sched_update_val    (tx_sched_update_val),
        .tx_sched_update_flowid (tx_sched_update_flowid),
        .tx_sched_update_more   (tx_sched_update_more),
        .sched_tx_update_rdy    (sched_tx_update_rdy),
        .sched_idle             (sched_idle),
        .sched_issue_cnt        (sched_issue_cnt)
    );

    typedef struct {
        logic [7:0] app_mask;
        logic [7:0] rx_mask;
        int         n;
        int         order[8];
    } vec_t;

    vec_t vecs[5];
    int   exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   auto_upd;
    bit   have_inflight;
    int   inflight;
    int   upd_wait;
    int   more_left[8];
    int   exp_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: monitor offers at negedge, then release one-shot inputs and run the TX model
    task automatic step();
        int e;
        @(negedge clk);
        if (sched_tx_req_val && tx_sched_req_rdy) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_issue: got flow %0d expected none", sched_tx_req_flowid);
            end else begin
                e = exp_q.pop_front();
                chk("issue_order", 32'(sched_tx_req_flowid), e);
            end
            have_inflight = 1'b1;
            inflight      = int'(sched_tx_req_flowid);
            upd_wait      = 2;
        end
        @(posedge clk);
        #1;
        app_sched_wake_val  = 1'b0;
        rx_sched_wake_val   = 1'b0;
        flow_disable_val    = 1'b0;
        tx_sched_update_val = 1'b0;
        if (auto_upd && have_inflight) begin
            if (upd_wait == 0) begin
                tx_sched_update_val    = 1'b1;
                tx_sched_update_flowid = inflight[2:0];
                tx_sched_update_more   = (more_left[inflight] > 0);
                if (more_left[inflight] > 0) more_left[inflight]--;
                have_inflight = 1'b0;
            end else begin
                upd_wait--;
            end
        end
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        repeat (3) step();
        while (!(sched_idle && exp_q.size() == 0 && !have_inflight) && k < 200) begin
            step();
            k++;
        end
        chk({name, "_in_time"}, 32'(k < 200), 1);
        chk({name, "_all_issued"}, exp_q.size(), 0);
        chk({name, "_idle"}, 32'(sched_idle), 1);
    endtask

    task automatic wait_inflight(input string name);
        int k;
        k = 0;
        while (!have_inflight && k < 50) begin
            step();
            k++;
        end
        chk({name, "_accepted"}, 32'(have_inflight), 1);
    endtask

    task automatic wake_app(input int f);
        app_sched_wake_val    = 1'b1;
        app_sched_wake_flowid = f[2:0];
    endtask

    initial begin
        int app_l[$];
        int rx_l[$];
        int ncyc;

        rst                    = 1'b0;
        app_sched_wake_val     = 1'b0;
        app_sched_wake_flowid  = '0;
        rx_sched_wake_val      = 1'b0;
        rx_sched_wake_flowid   = '0;
        flow_disable_val       = 1'b0;
        flow_disable_flowid    = '0;
        tx_sched_req_rdy       = 1'b0;
        tx_sched_update_val    = 1'b0;
        tx_sched_update_flowid = '0;
        tx_sched_update_more   = 1'b0;
        auto_upd               = 1'b1;
        have_inflight          = 1'b0;
        inflight               = 0;
        upd_wait               = 0;
        foreach (more_left[i]) more_left[i] = 0;

        vecs[0].app_mask = 8'h4A; vecs[0].rx_mask = 8'h00; vecs[0].n = 3;
        vecs[0].order = '{1, 3, 6, 0, 0, 0, 0, 0};
        vecs[1].app_mask = 8'h05; vecs[1].rx_mask = 8'h80; vecs[1].n = 3;
        vecs[1].order = '{7, 0, 2, 0, 0, 0, 0, 0};
        vecs[2].app_mask = 8'h04; vecs[2].rx_mask = 8'h20; vecs[2].n = 2;
        vecs[2].order = '{5, 2, 0, 0, 0, 0, 0, 0};
        vecs[3].app_mask = 8'h18; vecs[3].rx_mask = 8'h08; vecs[3].n = 2;
        vecs[3].order = '{3, 4, 0, 0, 0, 0, 0, 0};
        vecs[4].app_mask = 8'h0F; vecs[4].rx_mask = 8'hF0; vecs[4].n = 8;
        vecs[4].order = '{0, 1, 2, 3, 4, 5, 6, 7};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_val", 32'(sched_tx_req_val), 0);
        chk("rst_req_flowid", 32'(sched_tx_req_flowid), 0);
        chk("rst_update_rdy", 32'(sched_tx_update_rdy), 0);
        chk("rst_idle", 32'(sched_idle), 1);
        chk("rst_cnt", sched_issue_cnt, 0);
        chk("app_wake_rdy", 32'(sched_app_wake_rdy), 1);
        chk("rx_wake_rdy", 32'(sched_rx_wake_rdy), 1);
        rst = 1'b1;
        step();

        // Single wake: two-cycle latency to offer
        tx_sched_req_rdy = 1'b0;
        wake_app(5);
        step();
        chk("t1_val_t1", 32'(sched_tx_req_val), 0);
        step();
        chk("t1_val_t2", 32'(sched_tx_req_val), 1);
        chk("t1_flowid_t2", 32'(sched_tx_req_flowid), 5);
        chk("t1_idle_busy", 32'(sched_idle), 0);
        exp_q.push_back(5);
        tx_sched_req_rdy = 1'b1;
        step();
        chk("t1_cnt", sched_issue_cnt, 1);
        wait_idle("t1");

        // Reset while an offer is up: pending state is lost
        tx_sched_req_rdy = 1'b0;
        wake_app(6);
        step();
        step();
        chk("mr_val_before", 32'(sched_tx_req_val), 1);
        chk("mr_flowid_before", 32'(sched_tx_req_flowid), 6);
        rst = 1'b0;
        #1;
        chk("mr_val", 32'(sched_tx_req_val), 0);
        chk("mr_idle", 32'(sched_idle), 1);
        chk("mr_cnt", sched_issue_cnt, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        tx_sched_req_rdy = 1'b1;
        repeat (5) step();
        chk("mr_no_reissue", sched_issue_cnt, 0);

        // Table: wakes loaded with the offer held, then drained in round-robin order
        exp_cnt = 0;
        foreach (vecs[v]) begin
            tx_sched_req_rdy = 1'b0;
            app_l.delete();
            rx_l.delete();
            for (int f = 0; f < 8; f++) begin
                if (vecs[v].app_mask[f]) app_l.push_back(f);
                if (vecs[v].rx_mask[f]) rx_l.push_back(f);
            end
            for (int j = 0; j < vecs[v].n; j++) exp_q.push_back(vecs[v].order[j]);
            ncyc = (app_l.size() > rx_l.size()) ? app_l.size() : rx_l.size();
            for (int c = 0; c < ncyc; c++) begin
                if (c < app_l.size()) wake_app(app_l[c]);
                if (c < rx_l.size()) begin
                    rx_sched_wake_val    = 1'b1;
                    rx_sched_wake_flowid = rx_l[c][2:0];
                end
                step();
            end
            tx_sched_req_rdy = 1'b1;
            wait_idle($sformatf("vec%0d", v));
            exp_cnt += vecs[v].n;
            chk($sformatf("vec%0d_cnt", v), sched_issue_cnt, exp_cnt);
        end

        // Re-arm on more=1 goes behind other pending flows
        more_left[2] = 1;
        exp_q.push_back(2);
        exp_q.push_back(4);
        exp_q.push_back(2);
        wake_app(2);
        step();
        step();
        step();
        wake_app(4);
        wait_idle("t3");
        chk("t3_cnt", sched_issue_cnt, 21);

        // Disable while offered and not accepted
        tx_sched_req_rdy = 1'b0;
        wake_app(7);
        step();
        step();
        chk("t4_val", 32'(sched_tx_req_val), 1);
        chk("t4_flowid", 32'(sched_tx_req_flowid), 7);
        flow_disable_val    = 1'b1;
        flow_disable_flowid = 3'd7;
        step();
        chk("t4_val_drop", 32'(sched_tx_req_val), 0);
        step();
        chk("t4_idle", 32'(sched_idle), 1);
        tx_sched_req_rdy = 1'b1;
        repeat (6) step();
        chk("t4_cnt", sched_issue_cnt, 21);
        chk("t4_idle_end", 32'(sched_idle), 1);

        // Disable while in flight blocks the re-arm; the drop only applies once
        auto_upd = 1'b0;
        exp_q.push_back(0);
        wake_app(0);
        wait_inflight("t5a");
        flow_disable_val    = 1'b1;
        flow_disable_flowid = 3'd0;
        step();
        tx_sched_update_val    = 1'b1;
        tx_sched_update_flowid = 3'd0;
        tx_sched_update_more   = 1'b1;
        have_inflight          = 1'b0;
        step();
        repeat (6) step();
        chk("t5_no_rearm_q", exp_q.size(), 0);
        chk("t5_idle", 32'(sched_idle), 1);
        chk("t5_cnt", sched_issue_cnt, 22);
        exp_q.push_back(0);
        exp_q.push_back(0);
        wake_app(0);
        wait_inflight("t5b");
        tx_sched_update_val    = 1'b1;
        tx_sched_update_flowid = 3'd0;
        tx_sched_update_more   = 1'b1;
        have_inflight          = 1'b0;
        step();
        wait_inflight("t5c");
        tx_sched_update_val    = 1'b1;
        tx_sched_update_flowid = 3'd0;
        tx_sched_update_more   = 1'b0;
        have_inflight          = 1'b0;
        step();
        repeat (4) step();
        chk("t5_rearm_q", exp_q.size(), 0);
        chk("t5_cnt2", sched_issue_cnt, 24);
        chk("t5_idle2", 32'(sched_idle), 1);
        auto_upd = 1'b1;

        // Dual-source wake, then a wake in the accept cycle: exactly two issues
        tx_sched_req_rdy = 1'b0;
        wake_app(3);
        rx_sched_wake_val    = 1'b1;
        rx_sched_wake_flowid = 3'd3;
        step();
        step();
        chk("t6_val", 32'(sched_tx_req_val), 1);
        chk("t6_flowid", 32'(sched_tx_req_flowid), 3);
        exp_q.push_back(3);
        exp_q.push_back(3);
        tx_sched_req_rdy = 1'b1;
        wake_app(3);
        wait_idle("t6");
        repeat (4) step();
        chk("t6_cnt", sched_issue_cnt, 26);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
